// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback path.
// Default geometry matches a 32 x 64-bit register file; register 0 is hardwired to zero.
package wb_pkg;

    localparam int WB_N     = 32;
    localparam int WB_BITS  = 64;
    localparam int ZERO_REG = 0;

    typedef struct packed {
        logic [$clog2(WB_N)-1:0] rd;
        logic [WB_BITS-1:0]      data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Ordered dual-push, single-pop circular queue exposing its storage for associative lookup.
// Latency: an entry pushed at edge k reaches the head in cycle k+1 when the queue was empty.
// Backpressure: none internally; the caller never pushes more than DEPTH-count entries.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push_a,
    input  logic [W-1:0]                    dat_a,
    input  logic                            push_b,
    input  logic [W-1:0]                    dat_b,
    input  logic                            pop,
    output logic [W-1:0]                    head_dat,
    output logic [$clog2(DEPTH):0]          count,
    output logic [$clog2(DEPTH)-1:0]        head_ptr,
    output logic [DEPTH-1:0][W-1:0]         mem_dat,
    output logic [DEPTH-1:0]                occ
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW-1:0]           slot_b;
    logic                    pop_ok;
    logic [DEPTH-1:0][W-1:0] mem;

    assign pop_ok = pop && (count != '0);
    // The second push lands behind the first, or takes the first slot when alone.
    assign slot_b = push_a ? wr_ptr + AW'(1) : wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_a) + AW'(push_b);
            rd_ptr <= rd_ptr + AW'(pop_ok);
            count  <= count + CW'(push_a) + CW'(push_b) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_a) begin
            mem[wr_ptr] <= dat_a;
        end
        if (push_b) begin
            mem[slot_b] <= dat_b;
        end
    end

    // A slot is occupied when its distance from the head is below the count.
    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i] = {1'b0, AW'(i) - rd_ptr} < count;
        end
    end

    assign head_dat = mem[rd_ptr];
    assign head_ptr = rd_ptr;
    assign mem_dat  = mem;

endmodule

// File: rtl/writeback_unit.sv
// Merges load and ALU results into an in-order queue that drives the register file write port.
// Latency: a result accepted at edge k is presented on the write port in cycle k+1 (empty queue).
// Backpressure: readiness from registered free space only; loads take priority for the last slot.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int N     = WB_N,
    parameter int Bits  = WB_BITS,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [$clog2(N)-1:0]       mem_rd,
    input  logic [Bits-1:0]            mem_data,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [$clog2(N)-1:0]       alu_rd,
    input  logic [Bits-1:0]            alu_data,
    output logic                       wr_en,
    output logic [$clog2(N)-1:0]       ptr_wr,
    output logic [Bits-1:0]            data_wr,
    input  logic [$clog2(N)-1:0]       byp_ptr_1,
    input  logic [$clog2(N)-1:0]       byp_ptr_2,
    output logic                       byp_hit_1,
    output logic                       byp_hit_2,
    output logic [Bits-1:0]            byp_data_1,
    output logic [Bits-1:0]            byp_data_2,
    output logic [$clog2(DEPTH):0]     pend_cnt
);

    localparam int PW = $clog2(N);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PW-1:0]   rd;
        logic [Bits-1:0] data;
    } entry_t;

    localparam int EW = $bits(entry_t);

    logic [CW-1:0]            free;
    logic                     mem_fire;
    logic                     alu_fire;
    logic                     push_mem;
    logic                     push_alu;
    entry_t                   mem_ent;
    entry_t                   alu_ent;
    entry_t                   head;
    logic [EW-1:0]            head_dat;
    logic [AW-1:0]            head_ptr;
    logic [DEPTH-1:0][EW-1:0] ents;
    logic [DEPTH-1:0]         occ;

    // Space is judged on the registered count; a same-cycle pop does not count.
    assign free      = CW'(DEPTH) - pend_cnt;
    assign mem_ready = free >= CW'(1);
    assign alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !mem_valid);

    assign mem_fire = mem_valid && mem_ready;
    assign alu_fire = alu_valid && alu_ready;
    assign push_mem = mem_fire && (mem_rd != PW'(ZERO_REG));
    assign push_alu = alu_fire && (alu_rd != PW'(ZERO_REG));

    assign mem_ent.rd   = mem_rd;
    assign mem_ent.data = mem_data;
    assign alu_ent.rd   = alu_rd;
    assign alu_ent.data = alu_data;

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_a   (push_mem),
        .dat_a    (mem_ent),
        .push_b   (push_alu),
        .dat_b    (alu_ent),
        .pop      (wr_en),
        .head_dat (head_dat),
        .count    (pend_cnt),
        .head_ptr (head_ptr),
        .mem_dat  (ents),
        .occ      (occ)
    );

    // The register file always accepts, so the head drains every cycle it exists.
    assign head    = head_dat;
    assign wr_en   = pend_cnt != '0;
    assign ptr_wr  = wr_en ? head.rd   : '0;
    assign data_wr = wr_en ? head.data : '0;

    // Walk oldest to youngest so the last match, nearest the tail, wins.
    function automatic logic [Bits:0] lookup(
        input logic [PW-1:0]            ptr,
        input logic [DEPTH-1:0][EW-1:0] q,
        input logic [DEPTH-1:0]         vld,
        input logic [AW-1:0]            hp
    );
        logic [Bits:0] res;
        logic [AW-1:0] idx;
        entry_t        e;
        res = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = hp + AW'(k);
            e   = q[idx];
            if ((ptr != PW'(ZERO_REG)) && vld[idx] && (e.rd == ptr)) begin
                res = {1'b1, e.data};
            end
        end
        return res;
    endfunction

    assign {byp_hit_1, byp_data_1} = lookup(byp_ptr_1, ents, occ, head_ptr);
    assign {byp_hit_2, byp_data_2} = lookup(byp_ptr_2, ents, occ, head_ptr);

endmodule
